alu_issue_ctrl: RTL and testbench

Sequential issue/write-back controller that sits on the operand/result side of the combinational master ALU. It accepts 32-bit instruction words over a valid/ready handshake and decodes them. It reads an internal 8×32 register file, evaluates the condition field against the flag register, drives the ALU ports, then writes the result and flags back. One instruction is in flight at a time, in a fixed 4-cycle sequence.

---
 rtl/alu_issue_pkg.sv | 56 +++++
 rtl/alu_issue_ctrl_cond_eval.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/write-back controller: opcodes, condition
// codes, FSM states, instruction field positions and flag bit indices.
package alu_issue_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_RSB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_ORR  = 4'h4;
   localparam logic [3:0] OP_EOR  = 4'h5;
   localparam logic [3:0] OP_MOVN = 4'h6;
   localparam logic [3:0] OP_MOV  = 4'h7;
   localparam logic [3:0] OP_LSL  = 4'h8;
   localparam logic [3:0] OP_LSR  = 4'h9;
   localparam logic [3:0] OP_ASR  = 4'hA;
   localparam logic [3:0] OP_CMP  = 4'hB;
   localparam logic [3:0] OP_RSVD_LO = 4'hC;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

   localparam int F_COND_LO = 28;
   localparam int F_OP_LO   = 24;
   localparam int F_S       = 23;
   localparam int F_RD_LO   = 20;
   localparam int F_RN_LO   = 17;
   localparam int F_RSVD    = 16;
   localparam int F_IV_LO   = 0;
   localparam int F_RM_LO   = 0;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic is_illegal(input logic [3:0] op);
      return op >= OP_RSVD_LO;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond_eval.sv
// Combinational condition-code evaluator: cond + {N,Z,C,V} -> pass.
module cond_eval
   import alu_issue_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;
   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      pass = 1'b0;
      case (cond)
         COND_EQ: pass = z;
         COND_NE: pass = !z;
         COND_CS: pass = c;
         COND_CC: pass = !c;
         COND_MI: pass = n;
         COND_PL: pass = !n;
         COND_VS: pass = v;
         COND_VC: pass = !v;
         COND_HI: pass = c && !z;
         COND_LS: pass = !c || z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = !z && (n == v);
         COND_LE: pass = z || (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for the combinational master ALU: one instruction
// in flight, fixed 4-cycle sequence. Macro ALU_ISSUE_COND_EXEC_EN enables conditional execution.
//
// state  | meaning
// IDLE   | instr_ready high, waiting for a handshake
// READ   | latch RF[Rn]/RF[Rm] operands and the condition result
// EXEC   | ALU settled; latch result and new flags
// WB     | done pulse; commit result/flags at the closing edge
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     instr_valid,
   input  logic [31:0]              instr,
   output logic                     instr_ready,
   output logic [31:0]              alu_reg1,
   output logic [31:0]              alu_reg2,
   output logic [15:0]              alu_iv,
   output logic [3:0]               alu_opcode,
   output logic [3:0]               alu_cond,
   output logic                     alu_s,
   output logic [3:0]               alu_flag,
   input  logic [31:0]              alu_result,
   input  logic [3:0]               alu_new_flag,
   output logic                     done,
   output logic                     skipped,
   output logic                     illegal,
   input  logic [$clog2(NREG)-1:0]  dbg_addr,
   output logic [31:0]              dbg_data,
   output logic [3:0]               flags
);

   state_t      state_q, state_d;
   logic [31:0] instr_q, op1_q, op2_q, res_q;
   logic [31:0] rf [NREG];
   logic [3:0]  nflag_q, flags_q;
   logic        cond_pass, cond_pass_q;
   logic        done_q, skipped_q, illegal_q;
   logic        ill, wr_rf, wr_flags;
   logic        rsvd_unused;

   logic [3:0]  cond_f, op_f;
   logic        s_f;
   logic [2:0]  rd_f, rn_f, rm_f;
   logic [15:0] iv_f;

   assign cond_f      = instr_q[F_COND_LO +: 4];
   assign op_f        = instr_q[F_OP_LO +: 4];
   assign s_f         = instr_q[F_S];
   assign rd_f        = instr_q[F_RD_LO +: 3];
   assign rn_f        = instr_q[F_RN_LO +: 3];
   assign rm_f        = instr_q[F_RM_LO +: 3];
   assign iv_f        = instr_q[F_IV_LO +: 16];
   assign rsvd_unused = instr_q[F_RSVD];

`ifdef ALU_ISSUE_COND_EXEC_EN
   cond_eval u_cond_eval (
      .cond  (cond_f),
      .flags (flags_q),
      .pass  (cond_pass)
   );
`else
   assign cond_pass = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (instr_valid) state_d = S_READ;
         S_READ:  state_d = S_EXEC;
         S_EXEC:  state_d = S_WB;
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // MOV/MOVN never touch flags; CMP updates them regardless of S
   assign ill      = is_illegal(op_f);
   assign wr_rf    = (state_q == S_WB) && !ill && cond_pass_q && (op_f != OP_CMP);
   assign wr_flags = (state_q == S_WB) && !ill && cond_pass_q &&
                     ((op_f == OP_CMP) || (s_f && (op_f != OP_MOVN) && (op_f != OP_MOV)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q     <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         res_q       <= '0;
         nflag_q     <= '0;
         flags_q     <= '0;
         cond_pass_q <= 1'b0;
         done_q      <= 1'b0;
         skipped_q   <= 1'b0;
         illegal_q   <= 1'b0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         if (state_q == S_IDLE && instr_valid) instr_q <= instr;
         if (state_q == S_READ) begin
            op1_q       <= rf[rn_f];
            op2_q       <= rf[rm_f];
            cond_pass_q <= cond_pass;
         end
         if (state_q == S_EXEC) begin
            res_q   <= alu_result;
            nflag_q <= alu_new_flag;
         end
         done_q    <= (state_q == S_EXEC);
         skipped_q <= (state_q == S_EXEC) && !ill && !cond_pass_q;
         illegal_q <= (state_q == S_EXEC) && ill;
         if (wr_rf)    rf[rd_f] <= res_q;
         if (wr_flags) flags_q  <= nflag_q;
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign alu_reg1    = op1_q;
   assign alu_reg2    = op2_q;
   assign alu_iv      = iv_f;
   assign alu_opcode  = op_f;
   assign alu_cond    = cond_f;
   assign alu_s       = s_f;
   assign alu_flag    = flags_q;
   assign flags       = flags_q;
   assign done        = done_q;
   assign skipped     = skipped_q;
   assign illegal     = illegal_q;
   assign dbg_data    = rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed table, random instructions
// against an instruction-level reference model, handshake timing and reset abort.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [31:0] alu_reg1, alu_reg2;
   logic [15:0] alu_iv;
   logic [3:0]  alu_opcode, alu_cond;
   logic        alu_s;
   logic [3:0]  alu_flag;
   logic [31:0] alu_result;
   logic [3:0]  alu_new_flag;
   logic        done, skipped, illegal;
   logic [2:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [3:0]  flags;

   int n_vec = 0;
   int n_err = 0;

`ifdef ALU_ISSUE_COND_EXEC_EN
   localparam bit COND_ON = 1'b1;
`else
   localparam bit COND_ON = 1'b0;
`endif

   alu_issue_ctrl #(.NREG(8)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .alu_reg1(alu_reg1), .alu_reg2(alu_reg2),
      .alu_iv(alu_iv), .alu_opcode(alu_opcode), .alu_cond(alu_cond), .alu_s(alu_s),
      .alu_flag(alu_flag), .alu_result(alu_result), .alu_new_flag(alu_new_flag),
      .done(done), .skipped(skipped), .illegal(illegal),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .flags(flags)
   );

   always #5 clk = ~clk;

   // Stand-in for the master ALU; returns {N,Z,C,V, result}
   function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [15:0] iv);
      logic [32:0] w;
      logic [31:0] r;
      logic        c, v;
      w = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'h0: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[31:0]; c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         4'h1, 4'hB: begin
            r = a - b; c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         4'h2: r = b - a;
         4'h3: r = a & b;
         4'h4: r = a | b;
         4'h5: r = a ^ b;
         4'h6: r = {16'h0, iv};
         4'h7: r = b;
         4'h8: r = a << iv[4:0];
         4'h9: r = a >> iv[4:0];
         4'hA: r = $signed(a) >>> iv[4:0];
         default: r = a;
      endcase
      return {r[31], (r == 32'h0), c, v, r};
   endfunction

   logic [35:0] alu_out;
   always_comb alu_out = alu_fn(alu_opcode, alu_reg1, alu_reg2, alu_iv);
   assign alu_result   = alu_out[31:0];
   assign alu_new_flag = alu_out[35:32];

   function automatic logic cond_ok(input logic [3:0] cnd, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      if (!COND_ON) return 1'b1;
      case (cnd)
         4'h0: return z;          4'h1: return !z;
         4'h2: return c;          4'h3: return !c;
         4'h4: return n;          4'h5: return !n;
         4'h6: return v;          4'h7: return !v;
         4'h8: return c && !z;    4'h9: return !c || z;
         4'hA: return n == v;     4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   logic [31:0] m_rf [8];
   logic [3:0]  m_flags;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_flags = '0;
   endtask

   task automatic model_exec(input logic [31:0] ins);
      logic [3:0]  op;
      logic [35:0] r;
      op = ins[27:24];
      r  = alu_fn(op, m_rf[ins[19:17]], m_rf[ins[2:0]], ins[15:0]);
      if (op < 4'hC && cond_ok(ins[31:28], m_flags)) begin
         if (op != 4'hB) m_rf[ins[22:20]] = r[31:0];
         if (op == 4'hB || (ins[23] && op != 4'h6 && op != 4'h7)) m_flags = r[35:32];
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("flags", {28'h0, flags}, {28'h0, m_flags});
      for (int i = 0; i < 8; i++) begin
         dbg_addr = i[2:0];
         #1;
         chk("rf", dbg_data, m_rf[i]);
      end
   endtask

   task automatic run_instr(input logic [31:0] ins, output logic got_skip, output logic got_ill);
      logic [3:0] op;
      logic       ill, ok;
      op  = ins[27:24];
      ill = (op >= 4'hC);
      ok  = cond_ok(ins[31:28], m_flags);
      @(negedge clk);
      chk("idle_ready", {31'h0, instr_ready}, 32'd1);
      instr = ins; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr = $urandom; instr_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("busy_ready", {31'h0, instr_ready}, 32'd0);
      chk("busy_done", {31'h0, done}, 32'd0);
      @(negedge clk);
      chk("alu_reg1", alu_reg1, m_rf[ins[19:17]]);
      chk("alu_reg2", alu_reg2, m_rf[ins[2:0]]);
      chk("alu_iv", {16'h0, alu_iv}, {16'h0, ins[15:0]});
      chk("alu_opcode", {28'h0, alu_opcode}, {28'h0, op});
      chk("alu_cond", {28'h0, alu_cond}, {28'h0, ins[31:28]});
      chk("alu_s", {31'h0, alu_s}, {31'h0, ins[23]});
      chk("alu_flag", {28'h0, alu_flag}, {28'h0, m_flags});
      instr_valid = 1'b0;
      @(negedge clk);
      chk("wb_done", {31'h0, done}, 32'd1);
      chk("wb_skipped", {31'h0, skipped}, {31'h0, (!ill && !ok)});
      chk("wb_illegal", {31'h0, illegal}, {31'h0, ill});
      got_skip = skipped; got_ill = illegal;
      model_exec(ins);
      @(negedge clk);
      chk("post_ready", {31'h0, instr_ready}, 32'd1);
      chk("post_done", {31'h0, done}, 32'd0);
      check_state();
   endtask

   typedef struct {
      logic [31:0] ins;
      logic [31:0] exp_rd;
      logic [3:0]  exp_flags;
      logic        exp_skip;
      logic        exp_ill;
   } vec_t;

   vec_t        tbl [7];
   logic [31:0] hs [3];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic gs, gi, rdy;
      int   idx;

      tbl[0] = '{32'hE610_0005, 32'd5,  4'b0000, 1'b0, 1'b0};   // MOVN R1,#5
      tbl[1] = '{32'hE620_0005, 32'd5,  4'b0000, 1'b0, 1'b0};   // MOVN R2,#5
      tbl[2] = '{32'hE0B2_0002, 32'd10, 4'b0000, 1'b0, 1'b0};   // ADDS R3,R1,R2
      tbl[3] = '{32'hEB02_0002, 32'd0,  4'b0110, 1'b0, 1'b0};   // CMP R1,R2
      tbl[4] = '{32'h1042_0002, COND_ON ? 32'd0 : 32'd10, 4'b0110, COND_ON, 1'b0}; // ADDNE R4
      tbl[5] = '{32'h0052_0002, 32'd10, 4'b0110, 1'b0, 1'b0};   // ADDEQ R5
      tbl[6] = '{32'hEDE2_0002, 32'd0,  4'b0110, 1'b0, 1'b1};   // opcode 1101 -> R6
      hs[0] = 32'hE670_0011; hs[1] = 32'hE670_0022; hs[2] = 32'hE670_0033;

      rst_n = 1'b0; instr_valid = 1'b0; instr = '0; dbg_addr = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, instr_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_skipped", {31'h0, skipped}, 32'd0);
      chk("rst_illegal", {31'h0, illegal}, 32'd0);
      chk("rst_reg1", alu_reg1, 32'd0);
      chk("rst_reg2", alu_reg2, 32'd0);
      chk("rst_iv_op", {alu_iv, alu_opcode, alu_cond, alu_flag, 3'b0, alu_s}, 32'd0);
      check_state();

      for (int i = 0; i < 7; i++) begin
         run_instr(tbl[i].ins, gs, gi);
         dbg_addr = tbl[i].ins[22:20];
         #1;
         chk("tbl_rd", dbg_data, tbl[i].exp_rd);
         chk("tbl_flags", {28'h0, flags}, {28'h0, tbl[i].exp_flags});
         chk("tbl_skip", {31'h0, gs}, {31'h0, tbl[i].exp_skip});
         chk("tbl_ill", {31'h0, gi}, {31'h0, tbl[i].exp_ill});
      end

      for (int i = 0; i < 40; i++) begin
         logic [31:0] ins;
         ins = $urandom;
         if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
         run_instr(ins, gs, gi);
      end

      // valid held high across three instructions
      @(negedge clk);
      instr = hs[0]; instr_valid = 1'b1; idx = 0;
      for (int k = 0; k < 12; k++) begin
         chk("hs_ready", {31'h0, instr_ready}, {31'h0, (k % 4 == 0)});
         chk("hs_done", {31'h0, done}, {31'h0, (k % 4 == 3)});
         rdy = instr_ready;
         @(posedge clk); #1;
         if (rdy) begin
            idx++;
            if (idx < 3) instr = hs[idx];
            else instr_valid = 1'b0;
         end
         @(negedge clk);
      end
      for (int i = 0; i < 3; i++) model_exec(hs[i]);
      check_state();

      // reset during EXEC of ADDS R4,R1,R2
      @(negedge clk);
      instr = 32'hE0C2_0002; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {31'h0, instr_ready}, 32'd1);
      model_reset();
      @(negedge clk);
      chk("mid_rst_done", {31'h0, done}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'h0, instr_ready}, 32'd1);
      chk("post_rst_done", {31'h0, done}, 32'd0);
      check_state();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
